multicycle_control_fsm: RTL and testbench

- Main control unit for the multicycle datapath; sits directly upstream of it and drives every mux select and write enable each cycle.
- Decodes the 6-bit opcode from the datapath's instruction register and sequences fetch/decode/execute/memory/writeback steps in the classic MIPS multicycle style.
- Also provides start/halt handshaking and a retired-instruction counter for the bench.

---
 rtl/multicycle_control_fsm.sv | 186 ++++++++++++++++++
 tb/tb_multicycle_control_fsm.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multicycle MIPS-style datapath.
// Moore control outputs, start/halt handshake, retired-instruction count.
module multicycle_control_fsm #(
  parameter int          CNT_W   = 16,
  parameter logic [5:0]  HALT_OP = 6'b111111
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [5:0]       opcode,
  output logic             IorD,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [3:0] {
    IDLE   = 4'd0,
    FETCH  = 4'd1,
    DECODE = 4'd2,
    MEMADR = 4'd3,
    MEMRD  = 4'd4,
    MEMWB  = 4'd5,
    MEMWR  = 4'd6,
    EXEC   = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9,
    ADDIEX = 4'd10,
    ADDIWB = 4'd11,
    JUMP   = 4'd12,
    HALT   = 4'd13
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_J    = 6'b000010;

  state_t cur;
  state_t nxt;
  logic   bad_op;
  logic   retire;

  // State register; reset drops straight to IDLE so no enable survives
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cur <= IDLE;
    else      cur <= nxt;
  end

  // Next-state sequencing and opcode decode
  always_comb begin
    nxt    = cur;
    bad_op = 1'b0;
    unique case (cur)
      IDLE:   nxt = start ? FETCH : IDLE;
      FETCH:  nxt = DECODE;
      DECODE: begin
        case (opcode)
          OP_LW,
          OP_SW:   nxt = MEMADR;
          OP_R:    nxt = EXEC;
          OP_BEQ:  nxt = BRANCH;
          OP_ADDI: nxt = ADDIEX;
          OP_J:    nxt = JUMP;
          default: begin
            if (opcode == HALT_OP) begin
              nxt = HALT;
            end else begin
              nxt    = FETCH;
              bad_op = 1'b1;
            end
          end
        endcase
      end
      MEMADR: nxt = (opcode == OP_SW) ? MEMWR : MEMRD;
      MEMRD:  nxt = MEMWB;
      MEMWB:  nxt = FETCH;
      MEMWR:  nxt = FETCH;
      EXEC:   nxt = ALUWB;
      ALUWB:  nxt = FETCH;
      BRANCH: nxt = FETCH;
      ADDIEX: nxt = ADDIWB;
      ADDIWB: nxt = FETCH;
      JUMP:   nxt = FETCH;
      HALT:   nxt = HALT;
      default: nxt = IDLE;
    endcase
  end

  // Last state of every real instruction; each returns to FETCH
  assign retire = (cur == MEMWB)  || (cur == MEMWR)  ||
                  (cur == ALUWB)  || (cur == BRANCH) ||
                  (cur == ADDIWB) || (cur == JUMP);

  // Sticky illegal flag and retired-instruction counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      if (bad_op) illegal <= 1'b1;
      if (retire) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Moore control outputs decoded from the current state
  always_comb begin
    IorD        = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    RegDst      = 1'b0;
    MemtoReg    = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = 2'b00;
    PCSrc       = 2'b00;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    unique case (cur)
      FETCH: begin
        IRWrite = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = 1'b1;
      end
      DECODE: ALUSrcB = 2'b11;
      MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      MEMRD: IorD = 1'b1;
      MEMWB: begin
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      EXEC: begin
        ALUSrcA = 1'b1;
        ALUOp   = 2'b10;
      end
      ALUWB: begin
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCSrc       = 2'b01;
        PCWriteCond = 1'b1;
      end
      ADDIEX: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      ADDIWB: RegWrite = 1'b1;
      JUMP: begin
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: ;
    endcase
  end

  assign busy   = (cur != IDLE) && (cur != HALT);
  assign halted = (cur == HALT);
  assign state  = cur;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Scoreboard bench for multicycle_control_fsm.
// Stimulus pushes per-cycle expectations; a monitor pops and compares.
module tb_multicycle_control_fsm;

  typedef struct packed {
    logic [3:0]  st;
    logic [14:0] ctrl;
    logic        busy;
    logic        halted;
    logic        illegal;
    logic [15:0] cnt;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        start;
  logic [5:0]  opcode;
  logic        IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite;
  logic        ALUSrcA, PCWrite, PCWriteCond;
  logic [1:0]  ALUSrcB, ALUOp, PCSrc;
  logic        busy, halted, illegal;
  logic [3:0]  state;
  logic [15:0] instr_count;

  exp_t sb[$];
  int   n_chk;
  int   n_fail;

  multicycle_control_fsm #(.CNT_W(16), .HALT_OP(6'b111111)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSrc(PCSrc), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond),
    .busy(busy), .halted(halted), .illegal(illegal),
    .state(state), .instr_count(instr_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-written control table:
  // {IorD,MemWrite,IRWrite,RegDst,MemtoReg,RegWrite,ALUSrcA,
  //  ALUSrcB,ALUOp,PCSrc,PCWrite,PCWriteCond}
  function automatic logic [14:0] ectrl(input logic [3:0] s);
    case (s)
      4'd1:    return 15'b0_0_1_0_0_0_0_01_00_00_1_0;
      4'd2:    return 15'b0_0_0_0_0_0_0_11_00_00_0_0;
      4'd3:    return 15'b0_0_0_0_0_0_1_10_00_00_0_0;
      4'd4:    return 15'b1_0_0_0_0_0_0_00_00_00_0_0;
      4'd5:    return 15'b0_0_0_0_1_1_0_00_00_00_0_0;
      4'd6:    return 15'b1_1_0_0_0_0_0_00_00_00_0_0;
      4'd7:    return 15'b0_0_0_0_0_0_1_00_10_00_0_0;
      4'd8:    return 15'b0_0_0_1_0_1_0_00_00_00_0_0;
      4'd9:    return 15'b0_0_0_0_0_0_1_00_01_01_0_1;
      4'd10:   return 15'b0_0_0_0_0_0_1_10_00_00_0_0;
      4'd11:   return 15'b0_0_0_0_0_1_0_00_00_00_0_0;
      4'd12:   return 15'b0_0_0_0_0_0_0_00_00_10_1_0;
      default: return 15'b0;
    endcase
  endfunction

  function automatic exp_t mk(input logic [3:0] s, input int c,
                              input logic il);
    exp_t e;
    e.st      = s;
    e.ctrl    = ectrl(s);
    e.busy    = (s != 4'd0) && (s != 4'd13);
    e.halted  = (s == 4'd13);
    e.illegal = il;
    e.cnt     = 16'(c);
    return e;
  endfunction

  // Expect one cycle of DUT output, then advance a clock
  task automatic cyc(input logic [3:0] s, input int c, input logic il);
    sb.push_back(mk(s, c, il));
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare on each falling clock edge and on reset assertion
  initial begin
    exp_t e;
    exp_t a;
    forever begin
      @(negedge clk or negedge rst);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a.st      = state;
        a.ctrl    = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite,
                     ALUSrcA, ALUSrcB, ALUOp, PCSrc, PCWrite, PCWriteCond};
        a.busy    = busy;
        a.halted  = halted;
        a.illegal = illegal;
        a.cnt     = instr_count;
        n_chk++;
        if (a !== e) begin
          n_fail++;
          $display("FAIL cycle_check t=%0t: got st=%0d ctrl=%b b=%b h=%b il=%b cnt=%0d, want st=%0d ctrl=%b b=%b h=%b il=%b cnt=%0d",
                   $time, a.st, a.ctrl, a.busy, a.halted, a.illegal, a.cnt,
                   e.st, e.ctrl, e.busy, e.halted, e.illegal, e.cnt);
        end
      end
    end
  end

  localparam logic [5:0] R   = 6'b000000;
  localparam logic [5:0] LW  = 6'b100011;
  localparam logic [5:0] SW  = 6'b101011;
  localparam logic [5:0] BEQ = 6'b000100;
  localparam logic [5:0] AD  = 6'b001000;
  localparam logic [5:0] J   = 6'b000010;
  localparam logic [5:0] BAD = 6'b110011;
  localparam logic [5:0] HLT = 6'b111111;

  initial begin
    n_chk  = 0;
    n_fail = 0;
    rst    = 1'b0;
    start  = 1'b0;
    opcode = 6'b0;
    @(posedge clk);
    #1;
    cyc(4'd0, 0, 1'b0);
    rst = 1'b1;
    repeat (5) cyc(4'd0, 0, 1'b0);
    start = 1'b1;
    cyc(4'd0, 0, 1'b0);
    // R-type, start dropped mid-program
    opcode = R;
    cyc(4'd1, 0, 1'b0);
    start = 1'b0;
    cyc(4'd2, 0, 1'b0);
    cyc(4'd7, 0, 1'b0);
    cyc(4'd8, 0, 1'b0);
    // lw
    opcode = LW;
    cyc(4'd1, 1, 1'b0);
    cyc(4'd2, 1, 1'b0);
    cyc(4'd3, 1, 1'b0);
    cyc(4'd4, 1, 1'b0);
    cyc(4'd5, 1, 1'b0);
    // sw
    opcode = SW;
    cyc(4'd1, 2, 1'b0);
    cyc(4'd2, 2, 1'b0);
    cyc(4'd3, 2, 1'b0);
    cyc(4'd6, 2, 1'b0);
    // beq
    opcode = BEQ;
    cyc(4'd1, 3, 1'b0);
    cyc(4'd2, 3, 1'b0);
    cyc(4'd9, 3, 1'b0);
    // j
    opcode = J;
    cyc(4'd1, 4, 1'b0);
    cyc(4'd2, 4, 1'b0);
    cyc(4'd12, 4, 1'b0);
    // addi
    opcode = AD;
    cyc(4'd1, 5, 1'b0);
    cyc(4'd2, 5, 1'b0);
    cyc(4'd10, 5, 1'b0);
    cyc(4'd11, 5, 1'b0);
    // illegal opcode: skipped, not counted
    opcode = BAD;
    cyc(4'd1, 6, 1'b0);
    cyc(4'd2, 6, 1'b0);
    // halt, start toggling ignored
    opcode = HLT;
    cyc(4'd1, 6, 1'b1);
    cyc(4'd2, 6, 1'b1);
    cyc(4'd13, 6, 1'b1);
    start = 1'b1;
    cyc(4'd13, 6, 1'b1);
    start = 1'b0;
    cyc(4'd13, 6, 1'b1);
    start = 1'b1;
    cyc(4'd13, 6, 1'b1);
    // reset out of HALT and run again
    rst = 1'b0;
    cyc(4'd0, 0, 1'b0);
    rst = 1'b1;
    cyc(4'd0, 0, 1'b0);
    opcode = BAD;
    cyc(4'd1, 0, 1'b0);
    cyc(4'd2, 0, 1'b0);
    opcode = J;
    cyc(4'd1, 0, 1'b1);
    cyc(4'd2, 0, 1'b1);
    cyc(4'd12, 0, 1'b1);
    opcode = SW;
    cyc(4'd1, 1, 1'b1);
    start = 1'b0;
    cyc(4'd2, 1, 1'b1);
    cyc(4'd3, 1, 1'b1);
    // MEMWR checked at the falling edge, then reset before next rise
    sb.push_back(mk(4'd6, 1, 1'b1));
    @(negedge clk);
    #3;
    sb.push_back(mk(4'd0, 0, 1'b0));
    rst = 1'b0;
    @(posedge clk);
    #1;
    cyc(4'd0, 0, 1'b0);
    rst = 1'b1;
    cyc(4'd0, 0, 1'b0);
    repeat (2) @(posedge clk);
    n_chk++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d left, want 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
